// File: rtl/sar_converter_pkg.sv
// Shared definitions for the SAR converter and its consumers.
// The generator and the bench take the result width from here.
package sar_converter_pkg;

  localparam int unsigned SarWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAck  = 2'd1,
    StConv = 2'd2
  } star_e;

endpackage

// File: rtl/sar_converter_if.sv
// Conversion handshake plus the DAC/comparator pair of the SAR converter.
// The converter uses the slave modport. The consumer side uses the master modport.
interface sar_converter_if #(
  parameter int unsigned WIDTH = 8
);

  logic             soc;
  logic             eoc;
  logic [WIDTH-1:0] numero;
  logic [WIDTH-1:0] dac_out;
  logic             cmp;

  modport master (
    output soc,
    output cmp,
    input  eoc,
    input  numero,
    input  dac_out
  );

  modport slave (
    input  soc,
    input  cmp,
    output eoc,
    output numero,
    output dac_out
  );

endinterface

// File: rtl/sar_converter.sv
// Successive-approximation converter controller: soc/eoc handshake, one comparator
// decision per clock, MSB first, result presented on numero when eoc rises.
module sar_converter
  import sar_converter_pkg::*;
#(
  parameter int unsigned WIDTH = SarWidth
) (
  input logic            clock,
  input logic            reset_,
  sar_converter_if.slave bus
);

  localparam logic [WIDTH-1:0] Msb  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] Lsb  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] Zero = '0;

  star_e            star_q, star_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] dac_q, dac_d;
  logic [WIDTH-1:0] numero_q, numero_d;
  logic             eoc_q, eoc_d;
  logic [WIDTH-1:0] trial;

  always_ff @(posedge clock) begin
    if (!reset_) begin
      star_q   <= StIdle;
      mask_q   <= Zero;
      dac_q    <= Zero;
      numero_q <= Zero;
      eoc_q    <= 1'b1;
    end else begin
      star_q   <= star_d;
      mask_q   <= mask_d;
      dac_q    <= dac_d;
      numero_q <= numero_d;
      eoc_q    <= eoc_d;
    end
  end

  // cmp reflects the code applied during the cycle now ending; drop the trial bit if too high.
  always_comb begin
    trial = bus.cmp ? dac_q : (dac_q & ~mask_q);
  end

  always_comb begin
    star_d   = star_q;
    mask_d   = mask_q;
    dac_d    = dac_q;
    numero_d = numero_q;
    eoc_d    = eoc_q;

    unique case (star_q)
      StIdle: begin
        if (bus.soc) begin
          eoc_d  = 1'b0;
          star_d = StAck;
        end
      end
      StAck: begin
        if (!bus.soc) begin
          dac_d  = Msb;
          mask_d = Msb;
          star_d = StConv;
        end
      end
      StConv: begin
        if (mask_q == Lsb) begin
          numero_d = trial;
          dac_d    = trial;
          mask_d   = Zero;
          eoc_d    = 1'b1;
          star_d   = StIdle;
        end else begin
          dac_d  = trial | (mask_q >> 1);
          mask_d = mask_q >> 1;
        end
      end
      default: begin
        star_d = StIdle;
        mask_d = Zero;
        eoc_d  = 1'b1;
      end
    endcase
  end

  assign bus.eoc     = eoc_q;
  assign bus.numero  = numero_q;
  assign bus.dac_out = dac_q;

endmodule

// File: tb/tb_sar_converter.sv
// Bench for sar_converter: ideal comparator on a random analog code, binary-search
// reference model for the DAC trial sequence and the final result.
module tb_sar_converter;
  import sar_converter_pkg::*;

  localparam int unsigned W = SarWidth;

  logic         clock = 1'b0;
  logic         reset_;
  logic [W-1:0] ain;
  logic [W-1:0] last_res;
  int           checks = 0;
  int           errors = 0;

  always #5 clock = ~clock;

  sar_converter_if #(.WIDTH(W)) bus ();

  // Ideal comparator: compares against the code currently on the DAC.
  assign bus.cmp = (ain >= bus.dac_out);

  sar_converter #(.WIDTH(W)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full handshake; hold = extra cycles soc stays high in ACK, toggle = wiggle soc in CONV.
  task automatic convert(input logic [W-1:0] a, input int hold, input bit toggle);
    logic [W-1:0] seq [W];
    logic [W-1:0] res;
    logic [W-1:0] code;
    logic [W-1:0] one;
    one = 1;
    res = '0;
    for (int k = int'(W) - 1; k >= 0; k--) begin
      code = res | (one << k);
      seq[int'(W) - 1 - k] = code;
      if (a >= code) res = code;
    end

    ain = a;
    check_eq("idle_eoc", 32'(bus.eoc), 32'd1);
    bus.soc = 1'b1;
    tick();
    check_eq("eoc_fall", 32'(bus.eoc), 32'd0);
    check_eq("numero_hold_ack", 32'(bus.numero), 32'(last_res));
    for (int h = 0; h < hold; h++) begin
      tick();
      check_eq("hold_eoc", 32'(bus.eoc), 32'd0);
      check_eq("hold_dac", 32'(bus.dac_out), 32'(last_res));
    end
    bus.soc = 1'b0;
    tick();
    for (int i = 0; i < int'(W); i++) begin
      check_eq("dac_seq", 32'(bus.dac_out), 32'(seq[i]));
      check_eq("conv_eoc", 32'(bus.eoc), 32'd0);
      check_eq("numero_hold_conv", 32'(bus.numero), 32'(last_res));
      if (toggle) bus.soc = 1'($urandom_range(0, 1));
      tick();
    end
    bus.soc = 1'b0;
    check_eq("eoc_rise", 32'(bus.eoc), 32'd1);
    check_eq("numero", 32'(bus.numero), 32'(res));
    check_eq("dac_final", 32'(bus.dac_out), 32'(res));
    last_res = res;
    for (int j = 0; j < 2; j++) begin
      ain = W'($urandom);
      tick();
      check_eq("idle_numero_stable", 32'(bus.numero), 32'(last_res));
      check_eq("idle_eoc_stable", 32'(bus.eoc), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_   = 1'b0;
    bus.soc  = 1'b0;
    ain      = '0;
    last_res = '0;
    tick();
    tick();
    check_eq("rst_eoc", 32'(bus.eoc), 32'd1);
    check_eq("rst_numero", 32'(bus.numero), 32'd0);
    check_eq("rst_dac", 32'(bus.dac_out), 32'd0);
    reset_ = 1'b1;
    tick();

    convert(W'(8'h5A), 0, 1'b0);
    convert(W'(8'hFF), 0, 1'b0);
    convert(W'(8'h00), 0, 1'b0);
    convert(W'(8'h01), 0, 1'b0);
    convert(W'($urandom), 5, 1'b0);
    convert(W'($urandom), 0, 1'b1);

    // Reset in the middle of a conversion.
    ain     = W'(8'h5A);
    bus.soc = 1'b1;
    tick();
    bus.soc = 1'b0;
    tick();
    tick();
    tick();
    tick();
    reset_ = 1'b0;
    tick();
    reset_ = 1'b1;
    check_eq("midrst_eoc", 32'(bus.eoc), 32'd1);
    check_eq("midrst_numero", 32'(bus.numero), 32'd0);
    check_eq("midrst_dac", 32'(bus.dac_out), 32'd0);
    last_res = '0;
    tick();
    check_eq("midrst_idle", 32'(bus.eoc), 32'd1);
    convert(W'($urandom), 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      convert(W'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
